// File: rtl/scene_pkg.sv
// scene_pkg: shared geometry, colour key and pipeline constants for the scene renderer.
package scene_pkg;
    localparam int FB_W     = 320;
    localparam int SPR_W    = 64;
    localparam int SPR_H    = 32;
    localparam int VD       = 480;
    localparam int PIPE_LAT = 2;
    typedef logic [11:0] rgb_t;
    localparam rgb_t KEY = 12'h0F0;
endpackage

// File: rtl/scene_render_if.sv
// scene_render_if: pixel stream, memory buses and sprite-position handshake of the renderer.
interface scene_render_if;
    import scene_pkg::*;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        visible;
    logic        p_tick;
    logic [16:0] bg_addr;
    rgb_t        bg_data;
    logic [10:0] spr_addr;
    rgb_t        spr_data;
    logic        pos_valid;
    logic        pos_ready;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    rgb_t        rgb;
    logic        vblank_pulse;
    modport master (
        output pixel_x, pixel_y, visible, p_tick, bg_data, spr_data, pos_valid, pos_x, pos_y,
        input  bg_addr, spr_addr, pos_ready, rgb, vblank_pulse
    );
    modport slave (
        input  pixel_x, pixel_y, visible, p_tick, bg_data, spr_data, pos_valid, pos_x, pos_y,
        output bg_addr, spr_addr, pos_ready, rgb, vblank_pulse
    );
endinterface

// File: rtl/sprite_pos_mailbox.sv
// sprite_pos_mailbox: one-deep position mailbox committed to the active sprite position at vblank start.
module sprite_pos_mailbox
    import scene_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_p_tick,
    input  logic [9:0] i_pixel_x,
    input  logic [9:0] i_pixel_y,
    input  logic       i_pos_valid,
    input  logic [9:0] i_pos_x,
    input  logic [9:0] i_pos_y,
    output logic       o_pos_ready,
    output logic [9:0] o_sx,
    output logic [9:0] o_sy,
    output logic       o_vblank_pulse
);
    logic       r_pend_full;
    logic [9:0] r_pend_x;
    logic [9:0] r_pend_y;
    logic [9:0] r_sx;
    logic [9:0] r_sy;
    logic       r_vblank;
    logic       w_accept;
    logic       w_commit;

    assign w_accept = i_pos_valid && !r_pend_full;
    assign w_commit = i_p_tick && i_pixel_x == 10'd0 && i_pixel_y == 10'(VD);

    // accept needs an empty mailbox, so a same-clk accept lands in pend and waits a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_full <= 1'b0;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_sx        <= 10'h3FF;
            r_sy        <= 10'h3FF;
            r_vblank    <= 1'b0;
        end else begin
            r_vblank <= w_commit;
            if (w_commit && r_pend_full) begin
                r_sx        <= r_pend_x;
                r_sy        <= r_pend_y;
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pend_x    <= i_pos_x;
                r_pend_y    <= i_pos_y;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign o_pos_ready    = !r_pend_full;
    assign o_sx           = r_sx;
    assign o_sy           = r_sy;
    assign o_vblank_pulse = r_vblank;
endmodule

// File: rtl/scene_render.sv
// scene_render: two-stage pixel pipeline compositing a chroma-keyed sprite over a x2-scaled background.
module scene_render
    import scene_pkg::*;
(
    input logic           clk,
    input logic           reset,
    scene_render_if.slave bus
);
    logic [9:0]  w_sx;
    logic [9:0]  w_sy;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_sx11;
    logic [10:0] w_sy11;
    logic [10:0] w_spr_addr;
    logic [16:0] w_row;
    logic [16:0] w_bg_addr;
    logic        w_hit;
    logic [16:0] r_bg_addr;
    logic [10:0] r_spr_addr;
    logic        r_hit_a;
    logic        r_vis_a;
    rgb_t        r_rgb;

    sprite_pos_mailbox u_mailbox (
        .clk            (clk),
        .reset          (reset),
        .i_p_tick       (bus.p_tick),
        .i_pixel_x      (bus.pixel_x),
        .i_pixel_y      (bus.pixel_y),
        .i_pos_valid    (bus.pos_valid),
        .i_pos_x        (bus.pos_x),
        .i_pos_y        (bus.pos_y),
        .o_pos_ready    (bus.pos_ready),
        .o_sx           (w_sx),
        .o_sy           (w_sy),
        .o_vblank_pulse (bus.vblank_pulse)
    );

    assign w_x    = {1'b0, bus.pixel_x};
    assign w_y    = {1'b0, bus.pixel_y};
    assign w_sx11 = {1'b0, w_sx};
    assign w_sy11 = {1'b0, w_sy};
    // row pitch of 320 as (y<<8)+(y<<6)
    assign w_row      = 17'(bus.pixel_y[9:1]);
    assign w_bg_addr  = (w_row << 8) + (w_row << 6) + 17'(bus.pixel_x[9:1]);
    // 11-bit compares keep sx+SPR_W from wrapping near the 10-bit limit
    assign w_hit      = w_x >= w_sx11 && w_x < w_sx11 + 11'(SPR_W) &&
                        w_y >= w_sy11 && w_y < w_sy11 + 11'(SPR_H);
    assign w_spr_addr = (w_y - w_sy11) * 11'(SPR_W) + (w_x - w_sx11);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bg_addr  <= '0;
            r_spr_addr <= '0;
            r_hit_a    <= 1'b0;
            r_vis_a    <= 1'b0;
            r_rgb      <= '0;
        end else if (bus.p_tick) begin
            r_bg_addr  <= w_bg_addr;
            r_spr_addr <= w_spr_addr;
            r_hit_a    <= w_hit;
            r_vis_a    <= bus.visible;
            r_rgb      <= !r_vis_a ? '0 : (r_hit_a && bus.spr_data != KEY) ? bus.spr_data : bus.bg_data;
        end
    end

    assign bus.bg_addr  = r_bg_addr;
    assign bus.spr_addr = r_spr_addr;
    assign bus.rgb      = r_rgb;
endmodule

// File: tb/tb_scene_render.sv
// tb_scene_render: randomized checks of scene_render against a pixel-level reference model.
module tb_scene_render;
    import scene_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    scene_render_if bus();
    scene_render dut (.clk(clk), .reset(reset), .bus(bus));

    logic [11:0] spr_mem [2048];
    int m_sx = 1023, m_sy = 1023, m_px = 0, m_py = 0;
    bit m_pend_full = 1'b0;
    int total = 0, bad = 0;

    function automatic logic [11:0] bg_fn(input logic [16:0] a);
        return {1'b0, a[10:0] ^ {4'b0, a[16:10]}};
    endfunction

    function automatic bit in_spr(input int x, input int y);
        return x >= m_sx && x < m_sx + SPR_W && y >= m_sy && y < m_sy + SPR_H;
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit v);
        logic [11:0] s;
        if (!v) return 12'h000;
        if (in_spr(x, y)) begin
            s = spr_mem[(y - m_sy) * SPR_W + (x - m_sx)];
            if (s != KEY) return s;
        end
        return bg_fn(17'((y / 2) * FB_W + x / 2));
    endfunction

    // synchronous memories with one clk of read latency
    always @(posedge clk) begin
        bus.bg_data  <= bg_fn(bus.bg_addr);
        bus.spr_data <= spr_mem[bus.spr_addr];
    end

    task automatic present(input int x, input int y, input bit v);
        bus.pixel_x = 10'(x);
        bus.pixel_y = 10'(y);
        bus.visible = v;
        bus.p_tick  = 1'b1;
        @(posedge clk); #1;
        bus.p_tick  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_pixel(input string n, input int x, input int y, input bit v);
        logic [11:0] e;
        e = exp_rgb(x, y, v);
        present(x, y, v);
        present(x, y, v);
        total++;
        if (bus.rgb !== e) begin
            bad++;
            $display("FAIL %s rgb at (%0d,%0d) got=%h want=%h", n, x, y, bus.rgb, e);
        end
        total++;
        if (bus.bg_addr !== 17'((y / 2) * FB_W + x / 2)) begin
            bad++;
            $display("FAIL %s bg_addr got=%0d want=%0d", n, bus.bg_addr, (y / 2) * FB_W + x / 2);
        end
        if (in_spr(x, y)) begin
            total++;
            if (bus.spr_addr !== 11'((y - m_sy) * SPR_W + (x - m_sx))) begin
                bad++;
                $display("FAIL %s spr_addr got=%0d want=%0d", n, bus.spr_addr, (y - m_sy) * SPR_W + (x - m_sx));
            end
        end
    endtask

    task automatic offer(input string n, input int x, input int y);
        bus.pos_valid = 1'b1;
        bus.pos_x = 10'(x);
        bus.pos_y = 10'(y);
        for (int i = 0; i < 20 && !bus.pos_ready; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (!bus.pos_ready) begin
            bad++;
            $display("FAIL %s pos_ready timeout got=0 want=1", n);
        end else begin
            @(posedge clk); #1;
            m_pend_full = 1'b1;
            m_px = x;
            m_py = y;
        end
        bus.pos_valid = 1'b0;
        total++;
        if (bus.pos_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s pos_ready after accept got=%b want=0", n, bus.pos_ready);
        end
    endtask

    task automatic commit(input string n);
        bit was_full;
        was_full = m_pend_full;
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'(VD);
        bus.visible = 1'b0;
        bus.p_tick  = 1'b1;
        @(posedge clk); #1;
        bus.p_tick  = 1'b0;
        if (m_pend_full) begin
            m_sx = m_px;
            m_sy = m_py;
            m_pend_full = 1'b0;
        end
        if (!was_full && bus.pos_valid) begin
            m_pend_full = 1'b1;
            m_px = bus.pos_x;
            m_py = bus.pos_y;
        end
        total++;
        if (bus.vblank_pulse !== 1'b1) begin
            bad++;
            $display("FAIL %s vblank_pulse got=%b want=1", n, bus.vblank_pulse);
        end
        total++;
        if (bus.pos_ready !== !m_pend_full) begin
            bad++;
            $display("FAIL %s pos_ready at commit got=%b want=%b", n, bus.pos_ready, !m_pend_full);
        end
        if (bus.pos_valid && !m_pend_full) begin
            m_pend_full = 1'b1;
            m_px = bus.pos_x;
            m_py = bus.pos_y;
        end
        @(posedge clk); #1;
        total++;
        if (bus.vblank_pulse !== 1'b0) begin
            bad++;
            $display("FAIL %s vblank_pulse width got=%b want=0", n, bus.vblank_pulse);
        end
    endtask

    task automatic reset_checks(input string n);
        total++;
        if (bus.rgb !== 12'h000) begin bad++; $display("FAIL %s rgb got=%h want=000", n, bus.rgb); end
        total++;
        if (bus.pos_ready !== 1'b1) begin bad++; $display("FAIL %s pos_ready got=%b want=1", n, bus.pos_ready); end
        total++;
        if (bus.vblank_pulse !== 1'b0) begin bad++; $display("FAIL %s vblank got=%b want=0", n, bus.vblank_pulse); end
        total++;
        if (bus.bg_addr !== 17'd0) begin bad++; $display("FAIL %s bg_addr got=%0d want=0", n, bus.bg_addr); end
        total++;
        if (bus.spr_addr !== 11'd0) begin bad++; $display("FAIL %s spr_addr got=%0d want=0", n, bus.spr_addr); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        reset = 1'b0;
        check_pixel("reset_bg00", 0, 0, 1'b1);
        check_pixel("reset_bg_corner", 639, 479, 1'b1);
        for (int i = 0; i < 16; i++)
            check_pixel("reset_bg_rand", $urandom_range(0, 639), $urandom_range(0, 479), 1'b1);
        commit("reset_commit_empty");
        check_pixel("reset_bg_after", 63, 31, 1'b1);
    endtask

    task automatic test_background;
        check_pixel("bg_5_7", 5, 7, 1'b1);
        total++;
        if (bus.bg_addr !== 17'd962) begin
            bad++;
            $display("FAIL bg_962 bg_addr got=%0d want=962", bus.bg_addr);
        end
        check_pixel("bg_edge", 639, 1, 1'b1);
    endtask

    task automatic test_sprite;
        offer("spr_offer", 100, 50);
        commit("spr_commit");
        check_pixel("spr_origin", 100, 50, 1'b1);
        check_pixel("spr_last", 163, 81, 1'b1);
        check_pixel("spr_right_out", 164, 50, 1'b1);
        check_pixel("spr_left_out", 99, 50, 1'b1);
        check_pixel("spr_below_out", 100, 82, 1'b1);
        check_pixel("spr_key", 105, 50, 1'b1);
        check_pixel("spr_mid", 130, 60, 1'b1);
    endtask

    task automatic test_handshake;
        offer("hs_first", 10, 10);
        bus.pos_valid = 1'b1;
        bus.pos_x = 10'd20;
        bus.pos_y = 10'd20;
        check_pixel("hs_stall_old", 100, 50, 1'b1);
        check_pixel("hs_stall_new", 10, 10, 1'b1);
        total++;
        if (bus.pos_ready !== 1'b0) begin
            bad++;
            $display("FAIL hs_stall pos_ready got=%b want=0", bus.pos_ready);
        end
        commit("hs_commit");
        bus.pos_valid = 1'b0;
        total++;
        if (bus.pos_ready !== 1'b0) begin
            bad++;
            $display("FAIL hs_second_accept pos_ready got=%b want=0", bus.pos_ready);
        end
        check_pixel("hs_at10", 10, 10, 1'b1);
        check_pixel("hs_not20_yet", 80, 20, 1'b1);
        commit("hs_commit2");
        check_pixel("hs_at20", 80, 20, 1'b1);
    endtask

    task automatic test_blank_stall;
        logic [11:0] e_rgb;
        logic [16:0] e_bg;
        logic [10:0] e_spr;
        check_pixel("blank_700", 700, 10, 1'b0);
        e_rgb = exp_rgb(30, 25, 1'b1);
        e_bg  = 17'(12 * FB_W + 15);
        e_spr = 11'((25 - m_sy) * SPR_W + (30 - m_sx));
        present(30, 25, 1'b1);
        present(30, 25, 1'b1);
        bus.pixel_x = 10'd200;
        bus.pixel_y = 10'd300;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.rgb !== e_rgb) begin bad++; $display("FAIL stall rgb got=%h want=%h", bus.rgb, e_rgb); end
            total++;
            if (bus.bg_addr !== e_bg) begin bad++; $display("FAIL stall bg_addr got=%0d want=%0d", bus.bg_addr, e_bg); end
            total++;
            if (bus.spr_addr !== e_spr) begin bad++; $display("FAIL stall spr_addr got=%0d want=%0d", bus.spr_addr, e_spr); end
        end
        bus.pos_valid = 1'b1;
        bus.pos_x = 10'd200;
        bus.pos_y = 10'd100;
        commit("same_clk_commit");
        bus.pos_valid = 1'b0;
        check_pixel("same_clk_not_yet", 210, 110, 1'b1);
        check_pixel("same_clk_old", 30, 25, 1'b1);
        commit("same_clk_commit2");
        check_pixel("same_clk_next", 210, 110, 1'b1);
    endtask

    task automatic test_reset_midframe;
        offer("mid_offer", 300, 300);
        present(210, 110, 1'b1);
        present(210, 110, 1'b1);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("mid_reset");
        reset = 1'b0;
        m_sx = 1023;
        m_sy = 1023;
        m_pend_full = 1'b0;
        check_pixel("mid_resume", 210, 110, 1'b1);
        commit("mid_commit");
        check_pixel("mid_no_pending", 300, 300, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [11:0] prev;
        int x, y;
        bit v, have;
        for (int r = 0; r < 4; r++) begin
            offer("b2b_offer", $urandom_range(0, 639), $urandom_range(0, 479));
            commit("b2b_commit");
            have = 1'b0;
            prev = '0;
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = m_sx - 3 + $urandom_range(0, 70);
                    y = m_sy - 3 + $urandom_range(0, 38);
                end else begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                end
                if (x < 0) x = 0;
                if (x > 799) x = 799;
                if (y < 0) y = 0;
                if (y > 524) y = 524;
                if (x == 0 && y == VD) x = 1;
                v = x < 640 && y < 480;
                present(x, y, v);
                if (have) begin
                    total++;
                    if (bus.rgb !== prev) begin
                        bad++;
                        $display("FAIL b2b rgb got=%h want=%h", bus.rgb, prev);
                    end
                end
                total++;
                if (bus.bg_addr !== 17'((y / 2) * FB_W + x / 2)) begin
                    bad++;
                    $display("FAIL b2b bg_addr got=%0d want=%0d", bus.bg_addr, (y / 2) * FB_W + x / 2);
                end
                prev = exp_rgb(x, y, v);
                have = 1'b1;
            end
            present(2, 2, 1'b1);
            total++;
            if (bus.rgb !== prev) begin
                bad++;
                $display("FAIL b2b_last rgb got=%h want=%h", bus.rgb, prev);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++)
            spr_mem[i] = (i % 13 == 7) ? KEY : (12'h800 | 12'($urandom_range(0, 2047)));
        spr_mem[5] = KEY;
        bus.pixel_x = '0;
        bus.pixel_y = '0;
        bus.visible = 1'b0;
        bus.p_tick = 1'b0;
        bus.pos_valid = 1'b0;
        bus.pos_x = '0;
        bus.pos_y = '0;
        test_reset();
        test_background();
        test_sprite();
        test_handshake();
        test_blank_stall();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
